// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP controller slice.
// State codes follow the IEEE 1149.1 encoding.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SEL_DR  = 4'h7,
    CAP_DR  = 4'h6,
    SH_DR   = 4'h2,
    EX1_DR  = 4'h1,
    PAU_DR  = 4'h3,
    EX2_DR  = 4'h0,
    UPD_DR  = 4'h5,
    SEL_IR  = 4'h4,
    CAP_IR  = 4'hE,
    SH_IR   = 4'hA,
    EX1_IR  = 4'h9,
    PAU_IR  = 4'hB,
    EX2_IR  = 4'h8,
    UPD_IR  = 4'hD
  } tap_state_e;

  localparam logic [7:0] DEFAULT_IR = 8'h01;

endpackage

// File: rtl/jtag_tap_controller_ir_mon.sv
// IR scan monitor: counts Shift-IR edges per scan and
// flags scans whose length differs from IR_LEN.
module jtag_ir_scan_monitor
  import jtag_pkg::*;
#(
  parameter int IR_LEN = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       state,
  output logic [CNT_W-1:0] ir_shift_count,
  output logic             ir_len_error
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(IR_LEN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_shift_count <= '0;
      ir_len_error   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == TLR),
        (state == CAP_IR): begin
          ir_shift_count <= '0;
          ir_len_error   <= 1'b0;
        end
        (state == SH_IR): begin
          if (ir_shift_count != '1)
            ir_shift_count <= ir_shift_count + 1'b1;
        end
        (state == UPD_IR): begin
          ir_len_error <= (ir_shift_count != LEN_C);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP state machine with Moore strobe decode
// and an IR scan length monitor.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int IR_LEN = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tms,
  output logic [3:0]       state,
  output logic             test_logic_reset,
  output logic             capture_ir,
  output logic             shift_ir,
  output logic             update_ir,
  output logic             capture_dr,
  output logic             shift_dr,
  output logic             update_dr,
  output logic             tdo_en,
  output logic             tdo_sel_ir,
  output logic [CNT_W-1:0] ir_shift_count,
  output logic             ir_len_error
);

  tap_state_e state_q;
  tap_state_e state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= TLR;
    else        state_q <= state_d;
  end

  assign state            = state_q;
  assign test_logic_reset = (state_q == TLR);
  assign capture_ir       = (state_q == CAP_IR);
  assign shift_ir         = (state_q == SH_IR);
  assign update_ir        = (state_q == UPD_IR);
  assign capture_dr       = (state_q == CAP_DR);
  assign shift_dr         = (state_q == SH_DR);
  assign update_dr        = (state_q == UPD_DR);
  assign tdo_en           = shift_ir | shift_dr;

  // every IR-column state from Select-IR-Scan down to Update-IR
  assign tdo_sel_ir = (state_q == SEL_IR) | (state_q == CAP_IR)
                    | (state_q == SH_IR)  | (state_q == EX1_IR)
                    | (state_q == PAU_IR) | (state_q == EX2_IR)
                    | (state_q == UPD_IR);

  jtag_ir_scan_monitor #(
    .IR_LEN (IR_LEN),
    .CNT_W  (CNT_W)
  ) u_ir_mon (
    .clk            (clk),
    .rst_n          (rst_n),
    .state          (state_q),
    .ir_shift_count (ir_shift_count),
    .ir_len_error   (ir_len_error)
  );

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller.
// Walks reset, escape, IR and DR scans with fixed expectations.
module tb_jtag_tap_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tms;
  logic [3:0] state;
  logic       test_logic_reset;
  logic       capture_ir, shift_ir, update_ir;
  logic       capture_dr, shift_dr, update_dr;
  logic       tdo_en, tdo_sel_ir;
  logic [7:0] ir_shift_count;
  logic       ir_len_error;

  int total  = 0;
  int passed = 0;
  int n_cap_ir, n_sh_ir, n_upd_ir;
  int n_cap_dr, n_sh_dr, n_upd_dr;
  int n_sel_ir, n_en_bad;

  jtag_tap_controller #(
    .IR_LEN (8),
    .CNT_W  (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tms              (tms),
    .state            (state),
    .test_logic_reset (test_logic_reset),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .tdo_en           (tdo_en),
    .tdo_sel_ir       (tdo_sel_ir),
    .ir_shift_count   (ir_shift_count),
    .ir_len_error     (ir_len_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clr();
    n_cap_ir = 0; n_sh_ir = 0; n_upd_ir = 0;
    n_cap_dr = 0; n_sh_dr = 0; n_upd_dr = 0;
    n_sel_ir = 0; n_en_bad = 0;
  endtask

  task automatic step(input logic t);
    tms = t;
    @(posedge clk);
    #1;
    n_cap_ir += int'(capture_ir);
    n_sh_ir  += int'(shift_ir);
    n_upd_ir += int'(update_ir);
    n_cap_dr += int'(capture_dr);
    n_sh_dr  += int'(shift_dr);
    n_upd_dr += int'(update_dr);
    n_sel_ir += int'(tdo_sel_ir);
    if (tdo_en !== (shift_ir | shift_dr)) n_en_bad++;
  endtask

  task automatic steps(input int n, input logic t);
    for (int i = 0; i < n; i++) step(t);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    tms   = 1'b0;
    step(0);
    step(0);
    chk("rst_state", 32'(state), 32'hF);
    chk("rst_tlr", 32'(test_logic_reset), 32'h1);
    chk("rst_strobes",
        32'({capture_ir, shift_ir, update_ir, capture_dr,
             shift_dr, update_dr, tdo_en, tdo_sel_ir}), 32'h0);
    chk("rst_err", 32'(ir_len_error), 32'h0);
    chk("rst_cnt", 32'(ir_shift_count), 32'h0);
    rst_n = 1'b1;

    // to Shift-DR, then escape with five tms=1
    step(0); step(1); step(0); step(0);
    chk("to_shdr", 32'(state), 32'h2);
    step(1); chk("esc1", 32'(state), 32'h1);
    step(1); chk("esc2", 32'(state), 32'h5);
    step(1); chk("esc3", 32'(state), 32'h7);
    step(1); chk("esc4", 32'(state), 32'h4);
    step(1); chk("esc5", 32'(state), 32'hF);

    // full 8-bit IR scan
    clr();
    step(0); step(1); step(1); step(0);
    chk("capir_state", 32'(state), 32'hE);
    chk("capir_sel", 32'(tdo_sel_ir), 32'h1);
    step(0);
    chk("shir_en", 32'(tdo_en), 32'h1);
    steps(7, 0);
    step(1); step(1); step(0);
    chk("ir_cap_n", 32'(n_cap_ir), 32'd1);
    chk("ir_sh_n", 32'(n_sh_ir), 32'd8);
    chk("ir_upd_n", 32'(n_upd_ir), 32'd1);
    chk("ir_cnt", 32'(ir_shift_count), 32'd8);
    chk("ir_err", 32'(ir_len_error), 32'h0);
    chk("ir_final", 32'(state), 32'hC);

    // paused IR scan: 4 + 4 shift edges
    clr();
    step(1); step(1); step(0); step(0);
    steps(3, 0);
    step(1);
    chk("pz_ex1", 32'(state), 32'h9);
    step(0); step(0); step(0);
    chk("pz_state", 32'(state), 32'hB);
    chk("pz_cnt", 32'(ir_shift_count), 32'd4);
    chk("pz_shift", 32'(shift_ir), 32'h0);
    step(1); step(0);
    steps(3, 0);
    step(1); step(1); step(0);
    chk("pz_sh_n", 32'(n_sh_ir), 32'd8);
    chk("pz_cnt_end", 32'(ir_shift_count), 32'd8);
    chk("pz_err", 32'(ir_len_error), 32'h0);

    // short scan of 6 shift edges
    step(1); step(1); step(0); step(0);
    steps(5, 0);
    step(1); step(1); step(0);
    chk("short_cnt", 32'(ir_shift_count), 32'd6);
    chk("short_err", 32'(ir_len_error), 32'h1);
    chk("short_hold", 32'(state), 32'hC);
    step(1); step(1); step(0); step(0);
    chk("recap_err", 32'(ir_len_error), 32'h0);
    chk("recap_cnt", 32'(ir_shift_count), 32'd0);
    steps(7, 0);
    step(1); step(1); step(0);
    chk("good_cnt", 32'(ir_shift_count), 32'd8);
    chk("good_err", 32'(ir_len_error), 32'h0);

    // 32-bit DR scan
    clr();
    step(1); step(0);
    chk("capdr", 32'(state), 32'h6);
    step(0);
    steps(31, 0);
    step(1); step(1);
    chk("dr_upd", 32'(state), 32'h5);
    chk("dr_cap_n", 32'(n_cap_dr), 32'd1);
    chk("dr_sh_n", 32'(n_sh_dr), 32'd32);
    chk("dr_upd_n", 32'(n_upd_dr), 32'd1);
    chk("dr_sel_ir", 32'(n_sel_ir), 32'd0);
    chk("dr_en_bad", 32'(n_en_bad), 32'd0);
    chk("dr_cnt", 32'(ir_shift_count), 32'd8);
    step(0);
    chk("dr_rti", 32'(state), 32'hC);

    // reset in the middle of an IR scan
    clr();
    step(1); step(1); step(0); step(0); step(0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mid_rst_state", 32'(state), 32'hF);
    chk("mid_rst_cnt", 32'(ir_shift_count), 32'd0);
    step(1);
    chk("mid_rst_upd", 32'(n_upd_ir), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
IEEE 1149.1 TAP state machine that sequences the JTAG instruction register and data registers from TMS. It decodes its 16-state FSM into the capture/shift/update strobes for the IR and the DR chain, and drives TDO enable and the IR/DR select for the TDO mux. It also counts IR shift cycles per scan and flags a scan whose length does not equal the IR width.

Parameters:
IR_LEN, 8, instruction register length in bits; the expected shift count per IR scan.
CNT_W, 8, width of the IR shift counter; must satisfy 2**CNT_W-1 >= IR_LEN.

Ports:
clk  input  1  TAP clock (TCK domain); all state changes on rising edge.
rst_n  input  1  synchronous active-low reset.
tms  input  1  test mode select, sampled on rising clk.
state  output  4  current TAP state, IEEE encoding.
test_logic_reset  output  1  high while in Test-Logic-Reset.
capture_ir  output  1  high while in Capture-IR.
shift_ir  output  1  high while in Shift-IR.
update_ir  output  1  high while in Update-IR.
capture_dr  output  1  high while in Capture-DR.
shift_dr  output  1  high while in Shift-DR.
update_dr  output  1  high while in Update-DR.
tdo_en  output  1  high while in Shift-IR or Shift-DR.
tdo_sel_ir  output  1  1 selects IR TDO, 0 selects DR TDO; high in all *-IR states from Select-IR-Scan through Update-IR.
ir_shift_count  output  CNT_W  number of clk edges spent in Shift-IR in the current or last IR scan.
ir_len_error  output  1  sticky flag: last IR scan shifted a count other than IR_LEN.

Behaviour:
- State encoding (hex): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions, written as tms=0 / tms=1:
  - TLR→RTI/TLR; RTI→RTI/SelDR.
  - SelDR→CapDR/SelIR; CapDR→ShDR/Ex1DR; ShDR→ShDR/Ex1DR; Ex1DR→PauseDR/UpdDR; PauseDR→PauseDR/Ex2DR; Ex2DR→ShDR/UpdDR; UpdDR→RTI/SelDR.
  - SelIR→CapIR/TLR; CapIR→ShIR/Ex1IR; ShIR→ShIR/Ex1IR; Ex1IR→PauseIR/UpdIR; PauseIR→PauseIR/Ex2IR; Ex2IR→ShIR/UpdIR; UpdIR→RTI/SelDR.
- Reset: on a rising edge with rst_n=0, state becomes TLR regardless of tms, ir_shift_count=0 and ir_len_error=0. Reset outputs: test_logic_reset=1, all other strobes 0, tdo_en=0, tdo_sel_ir=0. Reset mid-scan aborts the scan; no update strobe is issued.
- Strobes are Moore decodes of the state register with zero added latency. Each strobe is high for exactly the cycles the FSM occupies that state, so the IR acts on the same edge that leaves or stays in the state.
- Five consecutive tms=1 edges reach TLR from any state.
- ir_shift_count:
  - cleared to 0 while in CapIR;
  - +1 on every edge taken while in ShIR, including the exiting edge;
  - saturates at 2**CNT_W-1;
  - holds its value in Ex1IR, PauseIR and Ex2IR, so a paused scan keeps accumulating;
  - holds after UpdIR until the next CapIR;
  - cleared in TLR.
- ir_len_error:
  - set on the edge leaving UpdIR if ir_shift_count != IR_LEN, cleared on that same edge if equal;
  - cleared in CapIR and TLR;
  - otherwise holds.
- DR scans do not touch ir_shift_count or ir_len_error.

Decomposition:
- Shared package jtag_pkg: tap_state_e enum with the 16 encodings above, and localparam DEFAULT_IR=8'h01.
- The FSM plus decode is a single module.
- Optional sub-module jtag_ir_scan_monitor holds the shift counter and length check; it takes state as input.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with tms=0 → state=F, test_logic_reset=1, all strobes 0, ir_len_error=0.
- Escape: from ShDR apply tms=1 for 5 edges → state sequence 1,5,7,4,F.
- IR scan: from TLR apply tms 0,1,1,0,0, then tms=0 for 7 edges, then 1,1,0 → capture_ir high 1 cycle, shift_ir high 8 cycles, update_ir high 1 cycle, ir_shift_count=8, ir_len_error=0, final state=C.
- Paused IR scan: 4 shift edges, Ex1IR, PauseIR for 3 cycles, Ex2IR, then 4 more shift edges → ir_shift_count=8, no error, shift_ir low during the pause.
- Short IR scan: 6 shift edges then UpdIR → ir_len_error=1. Next correct 8-bit scan → ir_len_error=0 from CapIR onward.
- DR scan: from RTI apply tms 1,0,0, then 31 zeros, then 1,1 → capture_dr 1 cycle, shift_dr 32 cycles, update_dr 1 cycle, tdo_sel_ir=0 throughout, tdo_en high exactly in ShDR, ir_shift_count unchanged.
